gpio_in_sampler: RTL

Input-direction counterpart of the GPIO output register bank: samples WIDTH external pins through a synchronizer, detects rising and falling edges, latches them into sticky write-1-to-clear status registers, and raises a level interrupt for unmasked events. The host reads pin level, status and mask over the same sel/wen/ren/addr register bus the GPIO output bank uses. The block sits between the pad ring and the host bus.

---
 rtl/gpio_pkg.sv | 11 +
 rtl/gpio_in_sampler_if.sv | 26 ++
 rtl/gpio_sync.sv | 23 ++
 rtl/gpio_in_sampler.sv | 125 ++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: register addresses and default bus width.
package gpio_pkg;

    localparam int GPIO_WIDTH = 32;

    localparam logic [1:0] GPIO_ADDR_LEVEL = 2'd0;
    localparam logic [1:0] GPIO_ADDR_RISE  = 2'd1;
    localparam logic [1:0] GPIO_ADDR_FALL  = 2'd2;
    localparam logic [1:0] GPIO_ADDR_MASK  = 2'd3;

endpackage

// File: rtl/gpio_in_sampler_if.sv
// Host register bus for the GPIO input sampler (same sel/wen/ren/addr bus as the output bank).
interface gpio_in_sampler_if
    import gpio_pkg::*;
#(
    parameter int WIDTH = GPIO_WIDTH
);

    logic             sel;
    logic             wen;
    logic             ren;
    logic [1:0]       addr;
    logic [WIDTH-1:0] datain;
    logic [WIDTH-1:0] dataout;
    logic             rvalid;

    modport master (
        output sel, wen, ren, addr, datain,
        input  dataout, rvalid
    );

    modport slave (
        input  sel, wen, ren, addr, datain,
        output dataout, rvalid
    );

endinterface

// File: rtl/gpio_sync.sv
// WIDTH-bit two-flop synchronizer for asynchronous pad inputs, reset to 0.
module gpio_sync #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/gpio_in_sampler.sv
// GPIO input sampler: synchronized pin levels, sticky W1C edge status, masked level irq.
// Optional pin debounce filter enabled by defining GPIO_IN_DEBOUNCE_EN.
module gpio_in_sampler
    import gpio_pkg::*;
#(
    parameter int WIDTH  = GPIO_WIDTH,
    parameter int DB_DIV = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [WIDTH-1:0]   gpio_in,
    output logic               irq,
    gpio_in_sampler_if.slave   bus
);

    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] lvl;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise_st;
    logic [WIDTH-1:0] fall_st;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] w1c_rise;
    logic [WIDTH-1:0] w1c_fall;
    logic [WIDTH-1:0] rdata_next;
    logic [1:0]       warm_cnt;
    logic             warm_done;
    logic             warm_step;
    logic             wr;
    logic             rd;

    if (DB_DIV < 2) begin : g_db_div_check
        $error("DB_DIV must be at least 2");
    end

    gpio_sync #(.WIDTH(WIDTH)) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (gpio_in),
        .q    (s2)
    );

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int DIV_W = $clog2(DB_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] stable;
    logic             tick;

    assign tick   = (div_cnt == DIV_W'(DB_DIV - 1));
    assign stable = shadow ~^ s2;

    // A bit only moves when it matched across two consecutive ticks.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt <= '0;
            shadow  <= '0;
            lvl     <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            shadow  <= s2;
            lvl     <= (lvl & ~stable) | (s2 & stable);
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Warm-up counts ticks so the filtered level settles before edges are armed.
    assign warm_step = tick;
`else
    assign lvl       = s2;
    assign warm_step = 1'b1;
`endif

    assign warm_done = (warm_cnt == 2'd3);
    assign rise      = warm_done ? (lvl & ~prev) : '0;
    assign fall      = warm_done ? (~lvl & prev) : '0;

    assign wr       = bus.sel & bus.wen;
    assign rd       = bus.sel & bus.ren;
    assign w1c_rise = (wr && bus.addr == GPIO_ADDR_RISE) ? bus.datain : '0;
    assign w1c_fall = (wr && bus.addr == GPIO_ADDR_FALL) ? bus.datain : '0;

    always_comb begin
        rdata_next = mask;
        case (bus.addr)
            GPIO_ADDR_LEVEL: rdata_next = lvl;
            GPIO_ADDR_RISE:  rdata_next = rise_st;
            GPIO_ADDR_FALL:  rdata_next = fall_st;
            default:         rdata_next = mask;
        endcase
    end

    // Hardware edge set is OR-ed after the clear so it wins over a same-cycle W1C.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            warm_cnt    <= 2'd0;
            prev        <= '0;
            rise_st     <= '0;
            fall_st     <= '0;
            mask        <= '0;
            irq         <= 1'b0;
            bus.dataout <= '0;
            bus.rvalid  <= 1'b0;
        end else begin
            if (warm_step && !warm_done) begin
                warm_cnt <= warm_cnt + 2'd1;
            end
            prev    <= lvl;
            rise_st <= (rise_st & ~w1c_rise) | rise;
            fall_st <= (fall_st & ~w1c_fall) | fall;
            if (wr && bus.addr == GPIO_ADDR_MASK) begin
                mask <= bus.datain;
            end
            irq        <= |((rise_st | fall_st) & mask);
            bus.rvalid <= rd;
            if (rd) begin
                bus.dataout <= rdata_next;
            end
        end
    end

endmodule
